// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM of the multicycle MIPS core. Sequences the
//               shared datapath through fetch/decode/execute/memory/writeback
//               and stalls on the memory-ready handshake.
//               Optional bne support is built when BNE_SUPPORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BNE_SUPPORT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMRD    = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWR    = STATE_W'(5),
    RTYPE_EX = STATE_W'(6),
    RTYPE_WB = STATE_W'(7),
    BEQ_EX   = STATE_W'(8),
    ADDI_EX  = STATE_W'(9),
    ADDI_WB  = STATE_W'(10),
    JUMP_EX  = STATE_W'(11),
    TRAP     = STATE_W'(12)
`ifdef BNE_SUPPORT_EN
    , BNE_EX = STATE_W'(13)
`endif
  } state_t;

  state_t state_q, state_d;

  logic       fetch_q,      fetch_d;
  logic       jump_q,       jump_d;
  logic       branch_q,     branch_d;
  logic       iord_q,       iord_d;
  logic       mem_write_q,  mem_write_d;
  logic       reg_dst_q,    reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic       reg_write_q,  reg_write_d;
  logic       alu_src_a_q,  alu_src_a_d;
  logic [1:0] alu_src_b_q,  alu_src_b_d;
  logic [2:0] alu_ctrl_q,   alu_ctrl_d;
  logic [1:0] pc_src_q,     pc_src_d;
  logic       rtype_ex_q,   rtype_ex_d;
  logic       illegal_q,    illegal_d;
`ifdef BNE_SUPPORT_EN
  logic       branch_ne_q,  branch_ne_d;
`endif

  function automatic logic funct_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = funct_supported(funct) ? RTYPE_EX : TRAP;
          OP_BEQ:       state_d = BEQ_EX;
          OP_ADDI:      state_d = ADDI_EX;
          OP_J:         state_d = JUMP_EX;
`ifdef BNE_SUPPORT_EN
          OP_BNE:       state_d = BNE_EX;
`endif
          default:      state_d = TRAP;
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (mem_ready) state_d = FETCH;
      RTYPE_EX: state_d = RTYPE_WB;
      RTYPE_WB: state_d = FETCH;
      BEQ_EX:   state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      JUMP_EX:  state_d = FETCH;
      TRAP:     state_d = TRAP;
`ifdef BNE_SUPPORT_EN
      BNE_EX:   state_d = FETCH;
`endif
      default:  state_d = FETCH;
    endcase
  end

  // Moore outputs are decoded from the next state so they come out of flops.
  always_comb begin
    fetch_d      = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    iord_d       = 1'b0;
    mem_write_d  = 1'b0;
    reg_dst_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    alu_ctrl_d   = ALU_ADD;
    pc_src_d     = 2'b00;
    rtype_ex_d   = 1'b0;
`ifdef BNE_SUPPORT_EN
    branch_ne_d  = 1'b0;
`endif
    case (state_d)
      FETCH: begin
        fetch_d     = 1'b1;
        alu_src_b_d = 2'b01;
      end
      DECODE:   alu_src_b_d = 2'b11;
      MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      MEMRD:    iord_d = 1'b1;
      MEMWB: begin
        mem_to_reg_d = 1'b1;
        reg_write_d  = 1'b1;
      end
      MEMWR: begin
        iord_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      RTYPE_EX: begin
        alu_src_a_d = 1'b1;
        rtype_ex_d  = 1'b1;
      end
      RTYPE_WB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      BEQ_EX: begin
        alu_src_a_d = 1'b1;
        alu_ctrl_d  = ALU_SUB;
        pc_src_d    = 2'b01;
        branch_d    = 1'b1;
      end
      ADDI_EX: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      ADDI_WB:  reg_write_d = 1'b1;
      JUMP_EX: begin
        pc_src_d = 2'b10;
        jump_d   = 1'b1;
      end
      TRAP: ;
`ifdef BNE_SUPPORT_EN
      BNE_EX: begin
        alu_src_a_d = 1'b1;
        alu_ctrl_d  = ALU_SUB;
        pc_src_d    = 2'b01;
        branch_ne_d = 1'b1;
      end
`endif
      default:  alu_ctrl_d = 3'b000;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      illegal_q    <= 1'b0;
      fetch_q      <= 1'b1;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      iord_q       <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_src_a_q  <= 1'b0;
      alu_src_b_q  <= 2'b01;
      alu_ctrl_q   <= ALU_ADD;
      pc_src_q     <= 2'b00;
      rtype_ex_q   <= 1'b0;
`ifdef BNE_SUPPORT_EN
      branch_ne_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      illegal_q    <= illegal_d;
      fetch_q      <= fetch_d;
      jump_q       <= jump_d;
      branch_q     <= branch_d;
      iord_q       <= iord_d;
      mem_write_q  <= mem_write_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      pc_src_q     <= pc_src_d;
      rtype_ex_q   <= rtype_ex_d;
`ifdef BNE_SUPPORT_EN
      branch_ne_q  <= branch_ne_d;
`endif
    end
  end

  logic pc_write;
  logic take_branch;

  assign pc_write = (fetch_q & mem_ready) | jump_q;
`ifdef BNE_SUPPORT_EN
  assign take_branch = (branch_q & zero) | (branch_ne_q & ~zero);
`else
  assign take_branch = branch_q & zero;
`endif

  // An asserted reset suppresses every write strobe of the abandoned instruction.
  assign pc_en       = ~reset & (pc_write | take_branch);
  assign ir_write    = ~reset & fetch_q & mem_ready;
  assign mem_write   = ~reset & mem_write_q;
  assign reg_write   = ~reset & reg_write_q;
  assign iord        = iord_q;
  assign reg_dst     = reg_dst_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign alu_control = rtype_ex_q ? funct_alu(funct) : alu_ctrl_q;
  assign pc_src      = pc_src_q;
  assign illegal     = illegal_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed self-checking bench for multicycle_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam int STATE_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               mem_ready;
  logic               pc_en;
  logic               iord;
  logic               mem_write;
  logic               ir_write;
  logic               reg_dst;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_control;
  logic [1:0]         pc_src;
  logic               illegal;
  logic [STATE_W-1:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.STATE_W(STATE_W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lw_states[6];
    lw_states = '{0, 1, 2, 3, 4, 0};

    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_illegal", illegal, 0);
    check("rst_strobes", {pc_en, ir_write, mem_write, reg_write}, 4'b0000);
    tick();
    check("fetch_stall", state, 0);

    // lw
    mem_ready = 1'b1; op = 6'b100011;
    #1;
    check("fetch_ir_write", ir_write, 1);
    check("fetch_pc_en", pc_en, 1);
    check("fetch_src_b", alu_src_b, 2'b01);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lw_state%0d", i), state, lw_states[i]);
      check($sformatf("lw_regwr%0d", i), {reg_write, mem_to_reg}, (i == 4) ? 2'b11 : 2'b00);
      if (i == 1) check("decode_src_b", alu_src_b, 2'b11);
      if (i == 3) check("memrd_iord", iord, 1);
      if (i < 5) tick();
    end

    // sw with a three-cycle stall in MEMWR
    op = 6'b101011;
    tick();
    tick();
    check("sw_memadr", {state, alu_src_a, alu_src_b}, {4'd2, 1'b1, 2'b10});
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      check($sformatf("sw_wr%0d", i), {state, mem_write, iord}, {4'd5, 1'b1, 1'b1});
      tick();
    end
    check("sw_done", {state, mem_write}, {4'd0, 1'b0});

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    tick();
    tick();
    check("slt_ex", {state, alu_control, alu_src_a, alu_src_b}, {4'd6, 3'b111, 1'b1, 2'b00});
    funct = 6'b100010;
    #1;
    check("sub_alu", alu_control, 3'b110);
    funct = 6'b101010;
    tick();
    check("slt_wb", {state, reg_write, reg_dst, mem_to_reg}, {4'd7, 1'b1, 1'b1, 1'b0});
    tick();
    check("slt_done", state, 0);

    // beq, taken then not taken
    op = 6'b000100;
    tick();
    tick();
    zero = 1'b1;
    #1;
    check("beq_taken", {state, pc_en, pc_src, alu_control}, {4'd8, 1'b1, 2'b01, 3'b110});
    zero = 1'b0;
    #1;
    check("beq_not_taken", pc_en, 0);
    tick();
    check("beq_done", state, 0);

    // addi
    op = 6'b001000;
    tick();
    tick();
    check("addi_ex", {state, alu_src_a, alu_src_b, alu_control}, {4'd9, 1'b1, 2'b10, 3'b010});
    tick();
    check("addi_wb", {state, reg_write, reg_dst}, {4'd10, 1'b1, 1'b0});
    tick();

    // j
    op = 6'b000010;
    tick();
    tick();
    check("jump_ex", {state, pc_en, pc_src}, {4'd11, 1'b1, 2'b10});
    tick();
    check("jump_done", state, 0);

    // bne: real branch only when built with the option
    op = 6'b000101;
    tick();
    tick();
`ifdef BNE_SUPPORT_EN
    zero = 1'b0;
    #1;
    check("bne_taken", {state, pc_en, pc_src}, {4'd13, 1'b1, 2'b01});
    tick();
`else
    check("bne_trap", {state, illegal}, {4'd12, 1'b1});
    reset = 1'b1;
    tick();
    reset = 1'b0;
`endif
    check("bne_after", {state, illegal}, {4'd0, 1'b0});

    // illegal opcode traps and stays sticky
    op = 6'b111111;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("trap%0d", i), {state, illegal, pc_en, ir_write, mem_write, reg_write},
            {4'd12, 1'b1, 4'b0000});
      tick();
    end
    reset = 1'b1;
    #1;
    tick();
    check("trap_reset", {state, illegal}, {4'd0, 1'b0});
    check("reset_gates_ir", {ir_write, pc_en}, 2'b00);
    reset = 1'b0;
    #1;
    check("post_reset_fetch", {ir_write, pc_en}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core; sequences the shared PC / instruction-memory / register-file / ALU datapath through fetch, decode, execute, memory and writeback steps.
- Decodes opcode/funct from the instruction register and drives every datapath enable and mux select.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register and `state` debug port.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; forces FETCH on the next rising edge
- op  input  6  instruction[31:26] from the instruction register
- funct  input  6  instruction[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  data memory write strobe
- ir_write  output  1  instruction register load
- reg_dst  output  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  writeback select: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register-file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  output  2  ALU B select: 00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- alu_control  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  output  1  sticky: unsupported instruction trapped
- state  output  STATE_W  current state, for debug

Behaviour:
- Outputs are Moore (decoded from state), except pc_en and the mem_ready-gated strobes.
- Every output not listed for a state is 0; alu_control defaults to 010.
- Reset: state = FETCH (0). illegal = 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPE_EX 6, RTYPE_WB 7, BEQ_EX 8, ADDI_EX 9, ADDI_WB 10, JUMP_EX 11, TRAP 12.
- FETCH:
  - iord = 0, alu_src_a = 0, alu_src_b = 01, pc_src = 00.
  - ir_write = mem_ready; PC write = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE: alu_src_a = 0, alu_src_b = 11 (branch target precompute). Next state by op:
  - 100011 lw or 101011 sw → MEMADR
  - 000000 R-type → RTYPE_EX if funct ∈ {100000, 100010, 100100, 100101, 101010}, else TRAP
  - 000100 beq → BEQ_EX
  - 001000 addi → ADDI_EX
  - 000010 j → JUMP_EX
  - any other op → TRAP
- MEMADR: alu_src_a = 1, alu_src_b = 10. Next: MEMRD if op = lw, else MEMWR.
- MEMRD: iord = 1. Holds until mem_ready, then MEMWB.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next: FETCH.
- MEMWR: iord = 1, mem_write = 1. Holds until mem_ready, then FETCH.
  - mem_write stays asserted for every stalled cycle; the address must stay stable.
- RTYPE_EX: alu_src_a = 1, alu_src_b = 00. alu_control from funct:
  - 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Next: RTYPE_WB.
- RTYPE_WB: reg_dst = 1, reg_write = 1, mem_to_reg = 0. Next: FETCH.
- BEQ_EX: alu_src_a = 1, alu_src_b = 00, alu_control = 110, pc_src = 01, branch asserted internally. Next: FETCH.
- ADDI_EX: alu_src_a = 1, alu_src_b = 10, alu_control = 010. Next: ADDI_WB.
- ADDI_WB: reg_dst = 0, reg_write = 1. Next: FETCH.
- JUMP_EX: pc_src = 10, PC write = 1. Next: FETCH.
- TRAP: illegal = 1; all write strobes 0; stays in TRAP until reset.
- pc_en = pc_write | (branch & zero), evaluated combinationally within the cycle.
- Latency per instruction (mem_ready = 1 throughout):
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready = 0 cycle adds one cycle in FETCH / MEMRD / MEMWR.
- Reset mid-instruction: the in-flight instruction is abandoned, no further strobes are issued, and FETCH starts the next cycle.
- Unreachable encodings 13–15 → FETCH next cycle, with all outputs 0.

Optional Feature:
- Macro BNE_SUPPORT_EN.
- Defined:
  - op 000101 (bne) decodes to BNE_EX (encoding 13).
  - Same outputs as BEQ_EX, except pc_en = pc_write | (branch & !zero).
  - 3 cycles.
- Undefined: op 000101 → TRAP; encoding 13 behaves as unreachable.

Test Plan:
- Reset for 2 cycles, then release → state = 0, illegal = 0, all strobes 0; first cycle with mem_ready = 1 gives ir_write = 1, pc_en = 1.
- lw (op 100011), mem_ready = 1 → state sequence 0, 1, 2, 3, 4, 0; reg_write = 1 with mem_to_reg = 1 only in state 4.
- sw with mem_ready held 0 for 3 cycles in MEMWR → mem_write high for 4 consecutive cycles with iord = 1, then state = 0.
- R-type slt (funct 101010) → alu_control = 111 in state 6; reg_write with reg_dst = 1 in state 7; 4 cycles total.
- beq: zero = 1 → pc_en = 1 with pc_src = 01 in state 8; repeat with zero = 0 → pc_en = 0.
- op 111111 → TRAP, illegal = 1 and held for 10 cycles; assert reset → state = 0 and illegal = 0 next edge.
